// File: rtl/ssemi_adc_output_buffer_if.sv
// Sample-in / word-out stream bundle between the ADC decimator, the output
// buffer and the host fabric.
interface ssemi_adc_output_buffer_if #(
  parameter int DATA_WIDTH = 24,
  parameter int OUT_WIDTH  = 32
);
  logic                  i_valid;
  logic [DATA_WIDTH-1:0] i_data;
  logic [OUT_WIDTH-1:0]  o_data;
  logic                  o_valid;
  logic                  i_ready;

  modport slave (
    input  i_valid, i_data, i_ready,
    output o_data, o_valid
  );

  modport master (
    output i_valid, i_data, i_ready,
    input  o_data, o_valid
  );
endinterface

// File: rtl/ssemi_adc_output_buffer.sv
// FWFT FIFO that formats decimator samples into host words, absorbs host
// stalls, counts dropped samples and flags a fill watermark.
module ssemi_adc_output_buffer #(
  parameter int DATA_WIDTH = 24,
  parameter int OUT_WIDTH  = 32,
  parameter int FIFO_DEPTH = 16,
  parameter int WATERMARK  = 8
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_enable,
  input  logic                          i_clear,
  input  logic                          i_format,
  ssemi_adc_output_buffer_if.slave      bus,
  input  logic                          i_overflow_clr,
  output logic [$clog2(FIFO_DEPTH):0]   o_level,
  output logic                          o_empty,
  output logic                          o_full,
  output logic                          o_watermark,
  output logic                          o_overflow,
  output logic [15:0]                   o_drop_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  logic [OUT_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]        wrPtr_q, wrPtr_d;
  logic [AW-1:0]        rdPtr_q, rdPtr_d;
  logic [LW-1:0]        level_q, level_d;
  logic                 overflow_q, overflow_d;
  logic [15:0]          dropCount_q, dropCount_d;

  logic                 pushReq;
  logic                 pop;
  logic                 accept;
  logic                 drop;
  logic                 full;
  logic [OUT_WIDTH-1:0] fmtWord;

  assign full    = (level_q == LW'(FIFO_DEPTH));
  assign pushReq = i_enable & bus.i_valid & ~i_clear;
  assign pop     = bus.o_valid & bus.i_ready;
  // A full FIFO still accepts when the head leaves in the same cycle.
  assign accept  = pushReq & (~full | pop);
  assign drop    = pushReq & full & ~pop;

  always_comb begin
    if (i_format) begin
      fmtWord = OUT_WIDTH'(bus.i_data) << (OUT_WIDTH - DATA_WIDTH);
    end else begin
      fmtWord = OUT_WIDTH'($signed(bus.i_data));
    end
  end

  always_comb begin
    wrPtr_d     = wrPtr_q;
    rdPtr_d     = rdPtr_q;
    level_d     = level_q;
    overflow_d  = overflow_q;
    dropCount_d = dropCount_q;

    if (i_clear) begin
      wrPtr_d = '0;
      rdPtr_d = '0;
      level_d = '0;
    end else begin
      if (accept) wrPtr_d = wrPtr_q + AW'(1);
      if (pop)    rdPtr_d = rdPtr_q + AW'(1);
      case ({accept, pop})
        2'b10:   level_d = level_q + LW'(1);
        2'b01:   level_d = level_q - LW'(1);
        default: level_d = level_q;
      endcase
    end

    // A drop in the same cycle as a clear request wins over the clear.
    if (drop) begin
      overflow_d = 1'b1;
      if (i_overflow_clr) begin
        dropCount_d = 16'd1;
      end else if (dropCount_q != 16'hFFFF) begin
        dropCount_d = dropCount_q + 16'd1;
      end
    end else if (i_overflow_clr) begin
      overflow_d  = 1'b0;
      dropCount_d = '0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wrPtr_q     <= '0;
      rdPtr_q     <= '0;
      level_q     <= '0;
      overflow_q  <= 1'b0;
      dropCount_q <= '0;
    end else begin
      wrPtr_q     <= wrPtr_d;
      rdPtr_q     <= rdPtr_d;
      level_q     <= level_d;
      overflow_q  <= overflow_d;
      dropCount_q <= dropCount_d;
    end
  end

  // Storage is reset so the head word reads as zero straight out of reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (accept) begin
      mem_q[wrPtr_q] <= fmtWord;
    end
  end

  assign bus.o_data   = mem_q[rdPtr_q];
  assign bus.o_valid  = (level_q != '0);
  assign o_level      = level_q;
  assign o_empty      = (level_q == '0);
  assign o_full       = full;
  assign o_watermark  = (level_q >= LW'(WATERMARK));
  assign o_overflow   = overflow_q;
  assign o_drop_count = dropCount_q;

endmodule
